// File: rtl/loader_pkg.sv
// Shared types and constants for the UART boot-time program loader.
package loader_pkg;

  localparam logic [7:0] SYNC_CODE = 8'hA5;
  localparam logic [7:0] ACK_CODE  = 8'h06;
  localparam logic [7:0] NAK_CODE  = 8'h15;

  // Frame header and datapath field widths
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned LANE_W = 2;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CSUM,
    ST_RESP,
    ST_RUN
  } state_t;

  // States in which the idle timeout and rx_frame_err abort the frame
  function automatic logic in_frame(input state_t s);
    return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/loader_word_asm.sv
// Assembles little-endian payload bytes into 32-bit words and keeps the
// running 8-bit payload checksum.
module loader_word_asm
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic [LANE_W-1:0] lane,
  output logic [WORD_W-1:0] word,
  output logic              word_done,
  output logic [7:0]        csum
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  // The word register is reset as well so imem_wdata reads 0 out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane      <= '0;
      word      <= '0;
      word_done <= 1'b0;
      csum      <= '0;
    end else begin
      word_done <= 1'b0;
      if (clear) begin
        lane <= '0;
        csum <= '0;
      end else if (byte_valid) begin
        word[{lane, 3'b000} +: 8] <= byte_data;
        lane      <= lane + 1'b1;
        csum      <= csum + byte_data;
        word_done <= &lane;
      end
    end
  end

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: parses framed UART bytes into instruction-memory writes, holds
// the core in reset while loading and answers each frame with ACK or NAK.
module uart_program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter logic [7:0]  SYNC_BYTE   = SYNC_CODE,
  parameter logic [7:0]  ACK_BYTE    = ACK_CODE,
  parameter logic [7:0]  NAK_BYTE    = NAK_CODE,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              rx_frame_err,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready
);

  localparam int unsigned MAX_WORDS = 1 << ADDR_W;
  localparam int unsigned CNT_W     = $clog2(TIMEOUT_CYC + 1);

  state_t              state, next_state;
  logic [7:0]          len_lo;
  logic [LEN_W-1:0]    len, len_in, idx_ext;
  logic [ADDR_W:0]     word_idx;
  logic [CNT_W-1:0]    idle_cnt;
  logic [7:0]          resp_q, resp_next;
  logic                load_err_q;
  logic                timeout, abort, frame_start, data_byte, last_word;
  logic [LANE_W-1:0]   lane;
  logic [WORD_W-1:0]   word;
  logic                word_done;
  logic [7:0]          csum;

  assign len_in      = {rx_data, len_lo};
  assign idx_ext     = LEN_W'(word_idx);
  assign timeout     = (idle_cnt == CNT_W'(TIMEOUT_CYC));
  assign abort       = rx_frame_err || timeout;
  assign frame_start = ((state == ST_IDLE) || (state == ST_RUN)) &&
                       rx_valid && !rx_frame_err && (rx_data == SYNC_BYTE);
  assign data_byte   = (state == ST_DATA) && rx_valid && !abort;
  // The word index advances on the write pulse, so it already names the
  // current word by the time that word's last byte arrives.
  assign last_word   = (idx_ext + LEN_W'(1)) == len;

  loader_word_asm u_word_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (frame_start),
    .byte_valid (data_byte),
    .byte_data  (rx_data),
    .lane       (lane),
    .word       (word),
    .word_done  (word_done),
    .csum       (csum)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    resp_next  = NAK_BYTE;
    unique case (state)
      ST_IDLE, ST_RUN: begin
        if (frame_start) next_state = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (abort)         next_state = ST_RESP;
        else if (rx_valid) next_state = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (abort) next_state = ST_RESP;
        else if (rx_valid) begin
          if (32'(len_in) > MAX_WORDS) next_state = ST_RESP;
          else if (len_in == '0)       next_state = ST_CSUM;
          else                         next_state = ST_DATA;
        end
      end
      ST_DATA: begin
        if (abort)                                next_state = ST_RESP;
        else if (rx_valid && (&lane) && last_word) next_state = ST_CSUM;
      end
      ST_CSUM: begin
        if (abort) next_state = ST_RESP;
        else if (rx_valid) begin
          next_state = ST_RESP;
          if (rx_data == csum) resp_next = ACK_BYTE;
        end
      end
      ST_RESP: begin
        if (tx_ready) next_state = (resp_q == ACK_BYTE) ? ST_RUN : ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_valid  = (state == ST_RESP);
    cpu_rst   = (state != ST_RUN);
    load_done = (state == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_lo     <= '0;
      len        <= '0;
      word_idx   <= '0;
      idle_cnt   <= '0;
      resp_q     <= '0;
      load_err_q <= 1'b0;
    end else begin
      if (!in_frame(state) || rx_valid) idle_cnt <= '0;
      else                              idle_cnt <= idle_cnt + 1'b1;

      if ((state == ST_LEN_LO) && rx_valid && !abort) len_lo <= rx_data;
      if ((state == ST_LEN_HI) && rx_valid && !abort) len    <= len_in;

      if (frame_start)    word_idx <= '0;
      else if (word_done) word_idx <= word_idx + 1'b1;

      // Response byte is frozen on entry so tx_data stays stable under back-pressure
      if ((state != ST_RESP) && (next_state == ST_RESP)) resp_q <= resp_next;
      if ((state == ST_RESP) && tx_ready) load_err_q <= (resp_q == NAK_BYTE);
    end
  end

  assign imem_we    = word_done;
  assign imem_addr  = word_idx[ADDR_W-1:0];
  assign imem_wdata = word;
  assign tx_data    = resp_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Scoreboard bench for uart_program_loader: a frame-level model queues the
// expected writes and response byte; a monitor pops them as the DUT emits them.
module tb_uart_program_loader;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 50;
  localparam int MAXW    = 1 << ADDR_W;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;

  logic              clk = 1'b0;
  logic              rst;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_frame_err;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              load_done;
  logic              load_err;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready;

  uart_program_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_frame_err (rx_frame_err),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_rst      (cpu_rst),
    .load_done    (load_done),
    .load_err     (load_err),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t         exp_wr[$];
  logic [7:0]  exp_resp[$];
  logic [31:0] words[$];
  wr_t         mon_w;
  int          n_checks  = 0;
  int          n_errors  = 0;
  int          resp_seen = 0;
  bit          model_run = 1'b0;
  bit          model_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, pops expectations as outputs appear
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_we) begin
        if (exp_wr.size() == 0) check("unexpected_write", imem_we, 0);
        else begin
          mon_w = exp_wr.pop_front();
          check("imem_addr", imem_addr, mon_w.addr);
          check("imem_wdata", imem_wdata, mon_w.data);
        end
      end
      if (tx_valid) begin
        if (exp_resp.size() == 0) check("unexpected_tx", tx_valid, 0);
        else begin
          check("tx_data", tx_data, exp_resp[0]);
          if (tx_ready) begin
            void'(exp_resp.pop_front());
            resp_seen++;
          end
        end
      end
    end
  end

  // All tasks start and end one time unit after a rising edge
  task automatic send_byte(input logic [7:0] b, input bit err);
    int gap = $urandom_range(0, 3);
    repeat (gap) begin @(posedge clk); #1; end
    rx_valid = 1'b1;
    rx_data = b;
    rx_frame_err = err;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_frame_err = 1'b0;
  endtask

  task automatic send_noise(input int count);
    logic [7:0] b;
    for (int i = 0; i < count; i++) begin
      b = 8'($urandom);
      if (b == SYNC) b = 8'h00;
      send_byte(b, 1'b0);
    end
    if (model_run) check("run_ignores_noise", cpu_rst, 0);
  endtask

  task automatic send_sync();
    send_byte(SYNC, 1'b0);
    if (model_run) begin
      check("reload_cpu_rst", cpu_rst, 1);
      check("reload_load_done", load_done, 0);
      model_run = 1'b0;
    end
  endtask

  task automatic wait_resp(input int budget);
    int start = resp_seen;
    for (int i = 0; i < budget && resp_seen == start; i++) @(posedge clk);
    #1;
    check("response_seen", resp_seen != start, 1);
  endtask

  task automatic fill_words(input int n);
    words = {};
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  // csum_sel: -1 correct checksum, -2 corrupted, otherwise the literal byte
  task automatic send_frame(input logic [15:0] n, input int csum_sel, input int err_byte,
                            input bit stall, input bit hold);
    logic [7:0] pay[$];
    logic [7:0] sum, sent, resp;
    int nwr;
    pay = {};
    sum = 8'h00;
    if (n <= MAXW)
      for (int i = 0; i < int'(n); i++)
        for (int j = 0; j < 4; j++) pay.push_back(words[i][8*j +: 8]);
    foreach (pay[k]) sum = sum + pay[k];
    if (csum_sel == -1)      sent = sum;
    else if (csum_sel == -2) sent = sum + 8'd1;
    else                     sent = csum_sel[7:0];

    if (n > MAXW || stall) begin
      resp = NAK; nwr = 0;
    end else if (err_byte >= 0) begin
      resp = NAK; nwr = err_byte / 4;
    end else begin
      resp = (sent == sum) ? ACK : NAK; nwr = int'(n);
    end
    for (int i = 0; i < nwr; i++) exp_wr.push_back('{addr: i[ADDR_W-1:0], data: words[i]});
    exp_resp.push_back(resp);

    send_noise($urandom_range(0, 2));
    send_sync();
    send_byte(n[7:0], 1'b0);
    send_byte(n[15:8], 1'b0);
    if (n <= MAXW) begin
      if (stall) begin
        repeat (TIMEOUT - 10) begin @(posedge clk); #1; end
        check("no_early_timeout", tx_valid, 0);
      end else begin
        for (int k = 0; k < pay.size(); k++) begin
          if (k == err_byte) begin
            send_byte(pay[k], 1'b1);
            break;
          end
          send_byte(pay[k], 1'b0);
        end
        if (err_byte < 0) begin
          if (hold) tx_ready = 1'b0;
          send_byte(sent, 1'b0);
        end
      end
    end
    if (hold) begin
      // A byte arriving while the response is pending must be dropped
      for (int i = 0; i < 20; i++) begin
        rx_valid = (i == 5);
        rx_data  = SYNC;
        check("hold_tx_valid", tx_valid, 1);
        @(posedge clk); #1;
      end
      rx_valid = 1'b0;
      tx_ready = 1'b1;
    end
    wait_resp(TIMEOUT + 30);
    model_run = (resp == ACK);
    model_err = (resp == NAK);
    check("cpu_rst", cpu_rst, !model_run);
    check("load_done", load_done, model_run);
    check("load_err", load_err, model_err);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int rn;
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    rx_frame_err = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_imem_we", imem_we, 0);
    check("rst_imem_addr", imem_addr, 0);
    check("rst_imem_wdata", imem_wdata, 0);
    check("rst_load_done", load_done, 0);
    check("rst_load_err", load_err, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    rst = 1'b0;

    // Two-word program; its checksum byte (0xB6) is computed by the model
    words = '{32'h00000013, 32'h00100093};
    send_frame(16'd2, -1, -1, 1'b0, 1'b0);
    send_frame(16'd2, 0, -1, 1'b0, 1'b0);

    words = {};
    send_frame(16'd0, -1, -1, 1'b0, 1'b0);
    send_frame(16'd257, -1, -1, 1'b0, 1'b0);

    fill_words(2);
    send_frame(16'd2, -1, 2, 1'b0, 1'b0);
    fill_words(3);
    send_frame(16'd3, -1, -1, 1'b1, 1'b0);
    fill_words(4);
    send_frame(16'd4, -1, -1, 1'b0, 1'b0);

    fill_words(3);
    send_frame(16'd3, -1, -1, 1'b0, 1'b1);
    fill_words(5);
    send_frame(16'd5, -1, -1, 1'b0, 1'b0);

    fill_words(MAXW);
    send_frame(16'(MAXW), -1, -1, 1'b0, 1'b0);

    repeat (10) begin
      rn = $urandom_range(1, 12);
      fill_words(rn);
      send_frame(16'(rn), ($urandom_range(0, 3) == 0) ? -2 : -1, -1, 1'b0, 1'b0);
    end

    // Reset in the middle of a frame abandons it without a response
    send_sync();
    send_byte(8'h04, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_cpu_rst", cpu_rst, 1);
    check("midrst_load_done", load_done, 0);
    check("midrst_load_err", load_err, 0);
    check("midrst_tx_valid", tx_valid, 0);
    rst = 1'b0;
    model_run = 1'b0;
    model_err = 1'b0;
    fill_words(2);
    send_frame(16'd2, -1, -1, 1'b0, 1'b0);

    repeat (5) begin @(posedge clk); #1; end
    check("writes_drained", exp_wr.size(), 0);
    check("resp_drained", exp_resp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
